// File: rtl/mo_tape_ddram_loader_pkg.sv
// Shared types and defaults for the MO tape loader.
// Holds the loader FSM encoding and the tape placement constants.
package mo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } tape_ld_state_t;

    localparam logic [28:0] TAPE_BASE_ADDR = 29'h0300_0000;
    localparam logic [7:0]  TAPE_INDEX     = 8'd1;
    localparam logic [24:0] TAPE_MAX_BYTES = 25'h100_0000;

endpackage

// File: rtl/mo_tape_ddram_loader_if.sv
// ioctl download port plus DDRAM write port of the tape loader.
// slave is the loader side, master is the HPS/DDRAM side.
interface mo_tape_ddram_loader_if;

    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    logic        ddram_busy;
    logic        ddram_we;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic [7:0]  ddram_burstcnt;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        input  ioctl_wait,
        output ddram_busy,
        input  ddram_we,
        input  ddram_addr,
        input  ddram_din,
        input  ddram_be,
        input  ddram_burstcnt
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        output ioctl_wait,
        input  ddram_busy,
        output ddram_we,
        output ddram_addr,
        output ddram_din,
        output ddram_be,
        output ddram_burstcnt
    );

endinterface

// File: rtl/mo_tape_ddram_loader.sv
// Packs the HPS tape byte stream into 64-bit DDRAM words at a fixed
// base, throttling the HPS while a word write is outstanding.
module mo_tape_ddram_loader #(
    parameter logic [28:0] BASE_ADDR  = mo_pkg::TAPE_BASE_ADDR,
    parameter logic [7:0]  TAPE_INDEX = mo_pkg::TAPE_INDEX,
    parameter logic [24:0] MAX_BYTES  = mo_pkg::TAPE_MAX_BYTES
) (
    input  logic                   sysclk,
    input  logic                   reset,
    mo_tape_ddram_loader_if.slave  bus,
    output logic [24:0]            tape_len,
    output logic                   tape_ready,
    output logic                   overflow
);

    import mo_pkg::*;

    tape_ld_state_t state_q, state_d;

    logic        active;
    logic        active_q;
    logic        rise;

    logic [7:0]  lanes_q [8];
    logic [7:0]  lanes_w [8];
    logic [7:0]  mask_q, mask_w;
    logic [21:0] tag_q, tag_w;

    logic        pend_v_q, pend_v_d;
    logic [24:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;

    logic [24:0] tape_len_q, tape_len_d;
    logic        tape_ready_q, tape_ready_d;
    logic        overflow_q, overflow_d;
    logic        wait_q, wait_d;
    logic        we_q, we_d;
    logic        restart_q, restart_d;

    logic [28:0] waddr_q, waddr_d;
    logic [63:0] wdin_q, wdin_d;
    logic [7:0]  wbe_q, wbe_d;

    logic        init;
    logic        byte_in;
    logic        flush_req;
    logic        take;
    logic [24:0] take_addr;
    logic [7:0]  take_data;
    logic [25:0] take_end;
    logic        launch;

    assign active = bus.ioctl_download
                  & (bus.ioctl_index == TAPE_INDEX);
    assign rise   = active & ~active_q;

    always_comb begin
        state_d      = state_q;
        lanes_w      = lanes_q;
        mask_w       = mask_q;
        tag_w        = tag_q;
        pend_v_d     = pend_v_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        tape_len_d   = tape_len_q;
        tape_ready_d = tape_ready_q;
        overflow_d   = overflow_q;
        wait_d       = wait_q;
        we_d         = we_q;
        restart_d    = restart_q;
        waddr_d      = waddr_q;
        wdin_d       = wdin_q;
        wbe_d        = wbe_q;
        init         = 1'b0;
        byte_in      = 1'b0;
        flush_req    = 1'b0;
        take         = 1'b0;
        take_addr    = bus.ioctl_addr;
        take_data    = bus.ioctl_dout;
        take_end     = '0;
        launch       = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) tape_ready_d = 1'b1;
                state_d = IDLE;
                if (rise) begin
                    init    = 1'b1;
                    byte_in = bus.ioctl_wr;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!active) flush_req = 1'b1;
                else byte_in = bus.ioctl_wr;
            end
            WRITE: begin
                if (rise) restart_d = 1'b1;
                if (we_q && !bus.ddram_busy) begin
                    we_d    = 1'b0;
                    wait_d  = 1'b0;
                    mask_w  = '0;
                    state_d = FILL;
                    if (restart_q || rise) begin
                        init = 1'b1;
                    end else begin
                        if (pend_v_q) begin
                            take      = 1'b1;
                            take_addr = pend_addr_q;
                            take_data = pend_data_q;
                            pend_v_d  = 1'b0;
                        end
                        if (!active) flush_req = 1'b1;
                    end
                end
            end
        endcase

        // A new download wipes the previous tape's status and partial word
        if (init) begin
            tape_ready_d = 1'b0;
            tape_len_d   = '0;
            overflow_d   = 1'b0;
            mask_w       = '0;
            pend_v_d     = 1'b0;
            restart_d    = 1'b0;
        end

        if (byte_in) begin
            if (bus.ioctl_addr >= MAX_BYTES) begin
                overflow_d = 1'b1;
            end else if (bus.ioctl_addr[24:3] != tag_w
                         && mask_w != '0) begin
                pend_v_d    = 1'b1;
                pend_addr_d = bus.ioctl_addr;
                pend_data_d = bus.ioctl_dout;
                launch      = 1'b1;
            end else begin
                take = 1'b1;
            end
        end

        if (take) begin
            lanes_w[take_addr[2:0]] = take_data;
            mask_w[take_addr[2:0]]  = 1'b1;
            tag_w    = take_addr[24:3];
            take_end = {1'b0, take_addr} + 26'd1;
            if (take_end > {1'b0, MAX_BYTES})
                take_end = {1'b0, MAX_BYTES};
            if (take_end > {1'b0, tape_len_d})
                tape_len_d = take_end[24:0];
            if (take_addr[2:0] == 3'd7) launch = 1'b1;
        end

        if (flush_req && mask_w != '0) launch = 1'b1;

        if (launch) begin
            state_d = WRITE;
            we_d    = 1'b1;
            wait_d  = 1'b1;
            waddr_d = BASE_ADDR + {7'd0, tag_w};
            wbe_d   = mask_w;
            for (int i = 0; i < 8; i++)
                wdin_d[8*i +: 8] = lanes_w[i];
        end else if (flush_req) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= IDLE;
            active_q     <= 1'b0;
            mask_q       <= '0;
            tag_q        <= '0;
            pend_v_q     <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            tape_len_q   <= '0;
            tape_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
            wait_q       <= 1'b0;
            we_q         <= 1'b0;
            restart_q    <= 1'b0;
            waddr_q      <= '0;
            wdin_q       <= '0;
            wbe_q        <= '0;
            for (int i = 0; i < 8; i++) lanes_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            active_q     <= active;
            mask_q       <= mask_w;
            tag_q        <= tag_w;
            pend_v_q     <= pend_v_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            tape_len_q   <= tape_len_d;
            tape_ready_q <= tape_ready_d;
            overflow_q   <= overflow_d;
            wait_q       <= wait_d;
            we_q         <= we_d;
            restart_q    <= restart_d;
            waddr_q      <= waddr_d;
            wdin_q       <= wdin_d;
            wbe_q        <= wbe_d;
            lanes_q      <= lanes_w;
        end
    end

    assign bus.ioctl_wait     = wait_q;
    assign bus.ddram_we       = we_q;
    assign bus.ddram_addr     = waddr_q;
    assign bus.ddram_din      = wdin_q;
    assign bus.ddram_be       = wbe_q;
    assign bus.ddram_burstcnt = 8'd1;

    assign tape_len   = tape_len_q;
    assign tape_ready = tape_ready_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_mo_tape_ddram_loader.sv
// Randomized scoreboard bench for the tape DDRAM loader.
// A byte-list reference model predicts every DDRAM word write.
module tb_mo_tape_ddram_loader;

    localparam logic [28:0] BASE     = 29'h0300_0000;
    localparam logic [7:0]  TAPE_IDX = 8'd1;
    localparam int          MAXB     = 25'h100_0000;

    typedef struct {
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } wr_t;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [24:0] tape_len, s_tape_len;
    logic        tape_ready, s_tape_ready;
    logic        overflow, s_overflow;

    always #5 sysclk = ~sysclk;

    mo_tape_ddram_loader_if bus ();
    mo_tape_ddram_loader_if sbus ();

    mo_tape_ddram_loader u_dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .bus        (bus),
        .tape_len   (tape_len),
        .tape_ready (tape_ready),
        .overflow   (overflow)
    );

    mo_tape_ddram_loader #(.MAX_BYTES(25'd8)) u_small (
        .sysclk     (sysclk),
        .reset      (reset),
        .bus        (sbus),
        .tape_len   (s_tape_len),
        .tape_ready (s_tape_ready),
        .overflow   (s_overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    wr_t         exp_q[$];
    logic [24:0] addr_q[$];
    logic [7:0]  data_q[$];

    int unsigned m_len   = 0;
    bit          m_ready = 1'b0;
    bit          m_ovf   = 1'b0;

    bit busy_force = 1'b0;
    bit busy_rand  = 1'b0;
    int gap_max    = 0;

    int          s_cnt = 0;
    logic [63:0] s_din = '0;
    logic [7:0]  s_be  = '0;
    logic [28:0] s_addr = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    always @(posedge sysclk) begin
        #1;
        bus.ddram_busy = busy_force
                       | (busy_rand && ($urandom_range(0, 3) == 0));
    end

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Scoreboard monitor: every cycle with a write request is checked
    always @(negedge sysclk) begin
        if (!reset && bus.ddram_we) begin
            chk("wait_during_write", 64'(bus.ioctl_wait), 64'd1);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr %h din %h be %h",
                         bus.ddram_addr, bus.ddram_din, bus.ddram_be);
            end else if (bus.ddram_addr !== exp_q[0].addr
                      || bus.ddram_be !== exp_q[0].be
                      || (bus.ddram_din & lane_mask(exp_q[0].be))
                         !== (exp_q[0].din & lane_mask(exp_q[0].be))) begin
                n_err++;
                $display("FAIL ddram_word: got %h/%h/%h expected %h/%h/%h",
                         bus.ddram_addr, bus.ddram_din, bus.ddram_be,
                         exp_q[0].addr, exp_q[0].din, exp_q[0].be);
            end
            if (!bus.ddram_busy && exp_q.size() != 0)
                void'(exp_q.pop_front());
        end
    end

    always @(negedge sysclk) begin
        if (!reset && sbus.ddram_we && !sbus.ddram_busy) begin
            s_cnt++;
            s_din  = sbus.ddram_din;
            s_be   = sbus.ddram_be;
            s_addr = sbus.ddram_addr;
        end
    end

    task automatic push_word(input int unsigned tag,
                             input logic [63:0] din, input logic [7:0] be);
        wr_t w;
        w.addr = BASE + 29'(tag);
        w.din  = din;
        w.be   = be;
        exp_q.push_back(w);
    endtask

    // Reference: walk the byte list, emitting a word on tag change,
    // on a filled lane 7 and at the end of the file
    task automatic model_file();
        logic [63:0] din;
        logic [7:0]  be;
        int unsigned tag, a;
        din = '0; be = '0; tag = 0;
        m_len = 0; m_ovf = 1'b0;
        for (int i = 0; i < addr_q.size(); i++) begin
            a = addr_q[i];
            if (a >= MAXB) begin
                m_ovf = 1'b1;
                continue;
            end
            if (be != 0 && (a / 8) != tag) begin
                push_word(tag, din, be);
                be = '0;
            end
            din[8*(a%8) +: 8] = data_q[i];
            be[a%8] = 1'b1;
            tag = a / 8;
            if (a + 1 > m_len) m_len = a + 1;
            if (a % 8 == 7) begin
                push_word(tag, din, be);
                be = '0;
            end
        end
        if (be != 0) push_word(tag, din, be);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int guard = 0;
        while (bus.ioctl_wait && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_timeout: ioctl_wait %b required 0",
                     bus.ioctl_wait);
        end
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        tick();
        bus.ioctl_wr = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
    endtask

    task automatic run_file(input logic [7:0] idx, input string name);
        int guard = 0;
        if (idx == TAPE_IDX) begin
            model_file();
            m_ready = 1'b1;
        end
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        tick();
        tick();
        for (int i = 0; i < addr_q.size(); i++)
            send_byte(addr_q[i], data_q[i]);
        bus.ioctl_download = 1'b0;
        tick();
        while (idx == TAPE_IDX && !tape_ready && guard < 300) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        chk({name, "_ready"}, 64'(tape_ready), 64'(m_ready));
        chk({name, "_len"}, 64'(tape_len), 64'(m_len));
        chk({name, "_ovf"}, 64'(overflow), 64'(m_ovf));
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic seq_file(input int start, input int n);
        addr_q.delete();
        data_q.delete();
        for (int i = 0; i < n; i++) begin
            addr_q.push_back(25'(start + i));
            data_q.push_back(8'(start + i));
        end
    endtask

    task automatic rand_file(input int n);
        int unsigned a;
        addr_q.delete();
        data_q.delete();
        a = $urandom_range(0, 1000);
        for (int i = 0; i < n; i++) begin
            if (i != 0) begin
                case ($urandom_range(0, 9))
                    0:       a = $urandom_range(0, 2000);
                    1:       a = a;
                    default: a = a + 1;
                endcase
            end
            addr_q.push_back(25'(a));
            data_q.push_back(8'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bus.ioctl_download  = 1'b0;
        bus.ioctl_index     = 8'd0;
        bus.ioctl_wr        = 1'b0;
        bus.ioctl_addr      = '0;
        bus.ioctl_dout      = '0;
        sbus.ioctl_download = 1'b0;
        sbus.ioctl_index    = 8'd0;
        sbus.ioctl_wr       = 1'b0;
        sbus.ioctl_addr     = '0;
        sbus.ioctl_dout     = '0;
        sbus.ddram_busy     = 1'b0;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_we", 64'(bus.ddram_we), 64'd0);
        chk("rst_wait", 64'(bus.ioctl_wait), 64'd0);
        chk("rst_ready", 64'(tape_ready), 64'd0);
        chk("rst_len", 64'(tape_len), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_addr", 64'(bus.ddram_addr), 64'd0);
        chk("rst_be", 64'(bus.ddram_be), 64'd0);
        chk("rst_burst", 64'(bus.ddram_burstcnt), 64'd1);

        seq_file(0, 16);
        run_file(TAPE_IDX, "seq16");

        seq_file(0, 11);
        run_file(TAPE_IDX, "len11");

        busy_force = 1'b1;
        seq_file(0, 16);
        fork
            run_file(TAPE_IDX, "busy20");
            begin
                g = 0;
                while (!bus.ddram_we && g < 500) begin
                    @(negedge sysclk);
                    g++;
                end
                chk("busy20_we_seen", 64'(bus.ddram_we), 64'd1);
                for (int i = 0; i < 20; i++) begin
                    @(negedge sysclk);
                    chk("busy20_we_held", 64'(bus.ddram_we), 64'd1);
                end
                busy_force = 1'b0;
            end
        join

        seq_file(0, 6);
        addr_q.push_back(25'd100);
        data_q.push_back(8'h64);
        run_file(TAPE_IDX, "jump");

        seq_file(0, 16);
        run_file(8'd0, "other_idx");

        sbus.ioctl_index    = TAPE_IDX;
        sbus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            g = 0;
            while (sbus.ioctl_wait && g < 100) begin
                tick();
                g++;
            end
            sbus.ioctl_wr   = 1'b1;
            sbus.ioctl_addr = 25'(i);
            sbus.ioctl_dout = 8'(8'hA0 + i);
            tick();
            sbus.ioctl_wr = 1'b0;
        end
        sbus.ioctl_download = 1'b0;
        repeat (10) tick();
        chk("small_len", 64'(s_tape_len), 64'd8);
        chk("small_ovf", 64'(s_overflow), 64'd1);
        chk("small_ready", 64'(s_tape_ready), 64'd1);
        chk("small_writes", 64'(s_cnt), 64'd1);
        chk("small_din", s_din, 64'hA7A6_A5A4_A3A2_A1A0);
        chk("small_be", 64'(s_be), 64'hFF);
        chk("small_addr", 64'(s_addr), 64'(BASE));

        busy_force = 1'b1;
        seq_file(0, 8);
        model_file();
        bus.ioctl_index    = TAPE_IDX;
        bus.ioctl_download = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 8; i++) send_byte(addr_q[i], data_q[i]);
        g = 0;
        while (!bus.ddram_we && g < 100) begin
            tick();
            g++;
        end
        chk("rstmid_we_before", 64'(bus.ddram_we), 64'd1);
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        exp_q.delete();
        tick();
        chk("rstmid_we", 64'(bus.ddram_we), 64'd0);
        chk("rstmid_wait", 64'(bus.ioctl_wait), 64'd0);
        chk("rstmid_ready", 64'(tape_ready), 64'd0);
        reset = 1'b0;
        busy_force = 1'b0;
        m_ready = 1'b0;
        m_len = 0;
        m_ovf = 1'b0;
        tick();

        busy_rand = 1'b1;
        seq_file(40, 20);
        run_file(TAPE_IDX, "after_rst");

        for (int t = 0; t < 8; t++) begin
            gap_max = $urandom_range(0, 3);
            rand_file($urandom_range(1, 40));
            run_file(TAPE_IDX, "rand");
        end

        busy_rand = 1'b0;
        rand_file(12);
        run_file(8'd3, "rand_other");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
